// File: rtl/fifo36k_ctrl.sv
// Synchronous 1024 x 36 FIFO controller driving a true-dual-port 36K RAM.
// Port A is used only for writes and port B only for reads; read latency is one cycle.
module fifo36k_ctrl #(
    parameter int ALMOST_FULL_OFFSET  = 4,
    parameter int ALMOST_EMPTY_OFFSET = 4
) (
    input  logic        CLK,
    input  logic        RESET,
    input  logic        PUSH,
    input  logic [35:0] PUSH_DATA,
    input  logic        POP,
    output logic [35:0] POP_DATA,
    output logic        POP_VALID,
    output logic        FULL,
    output logic        EMPTY,
    output logic        ALMOST_FULL,
    output logic        ALMOST_EMPTY,
    output logic        OVERFLOW,
    output logic        UNDERFLOW,
    output logic [10:0] COUNT,
    output logic        RAM_WEN_A,
    output logic        RAM_REN_A,
    output logic [3:0]  RAM_BE_A,
    output logic [14:0] RAM_ADDR_A,
    output logic [31:0] RAM_WDATA_A,
    output logic [3:0]  RAM_WPARITY_A,
    output logic        RAM_WEN_B,
    output logic        RAM_REN_B,
    output logic [14:0] RAM_ADDR_B,
    input  logic [31:0] RAM_RDATA_B,
    input  logic [3:0]  RAM_RPARITY_B
);

    localparam logic [10:0] DEPTH  = 11'd1024;
    localparam logic [10:0] AF_OFF = 11'(ALMOST_FULL_OFFSET);
    localparam logic [10:0] AE_OFF = 11'(ALMOST_EMPTY_OFFSET);

    logic [9:0]  wr_ptr_q, wr_ptr_d;
    logic [9:0]  rd_ptr_q, rd_ptr_d;
    logic [10:0] count_q, count_d;
    logic        full_q, full_d;
    logic        empty_q, empty_d;
    logic        afull_q, afull_d;
    logic        aempty_q, aempty_d;
    logic        overflow_q, overflow_d;
    logic        underflow_q, underflow_d;
    logic        pop_valid_q, pop_valid_d;
    logic [35:0] pop_hold_q, pop_hold_d;

    logic push_acc;
    logic pop_acc;

    // Acceptance is gated by the registered flags only, so a pop cannot make room
    // for a push in the same cycle and a push cannot fall through to a pop.
    assign push_acc = PUSH && !full_q && !RESET;
    assign pop_acc  = POP && !empty_q && !RESET;

    always_comb begin
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        pop_hold_d  = pop_hold_q;
        if (push_acc) begin
            wr_ptr_d = wr_ptr_q + 10'd1;
        end
        if (pop_acc) begin
            rd_ptr_d = rd_ptr_q + 10'd1;
        end
        if (push_acc && !pop_acc) begin
            count_d = count_q + 11'd1;
        end else if (pop_acc && !push_acc) begin
            count_d = count_q - 11'd1;
        end
        // Capture the RAM word while it is presented so POP_DATA can hold it later.
        if (pop_valid_q) begin
            pop_hold_d = {RAM_RPARITY_B, RAM_RDATA_B};
        end
        full_d      = (count_d == DEPTH);
        empty_d     = (count_d == 11'd0);
        afull_d     = ((DEPTH - count_d) <= AF_OFF);
        aempty_d    = (count_d <= AE_OFF);
        overflow_d  = PUSH && full_q;
        underflow_d = POP && empty_q;
        pop_valid_d = pop_acc;
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            full_q      <= 1'b0;
            empty_q     <= 1'b1;
            afull_q     <= 1'b0;
            aempty_q    <= 1'b1;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
            pop_valid_q <= 1'b0;
            pop_hold_q  <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            full_q      <= full_d;
            empty_q     <= empty_d;
            afull_q     <= afull_d;
            aempty_q    <= aempty_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
            pop_valid_q <= pop_valid_d;
            pop_hold_q  <= pop_hold_d;
        end
    end

    assign COUNT        = count_q;
    assign FULL         = full_q;
    assign EMPTY        = empty_q;
    assign ALMOST_FULL  = afull_q;
    assign ALMOST_EMPTY = aempty_q;
    assign OVERFLOW     = overflow_q;
    assign UNDERFLOW    = underflow_q;
    assign POP_VALID    = pop_valid_q;
    assign POP_DATA     = pop_valid_q ? {RAM_RPARITY_B, RAM_RDATA_B} : pop_hold_q;

    // Pointers sit in the top address bits; the 36-bit-wide configuration ignores the low five.
    assign RAM_WEN_A     = push_acc;
    assign RAM_REN_A     = 1'b0;
    assign RAM_BE_A      = 4'b1111;
    assign RAM_ADDR_A    = {wr_ptr_q, 5'b00000};
    assign RAM_WDATA_A   = PUSH_DATA[31:0];
    assign RAM_WPARITY_A = PUSH_DATA[35:32];
    assign RAM_WEN_B     = 1'b0;
    assign RAM_REN_B     = pop_acc;
    assign RAM_ADDR_B    = {rd_ptr_q, 5'b00000};

endmodule

// File: tb/tb_fifo36k_ctrl.sv
// Directed bench for fifo36k_ctrl with a behavioural 1024 x 36 RAM and an expected-data queue.
module tb_fifo36k_ctrl;

    logic        clk;
    logic        RESET;
    logic        PUSH;
    logic [35:0] PUSH_DATA;
    logic        POP;
    logic [35:0] POP_DATA;
    logic        POP_VALID, FULL, EMPTY, ALMOST_FULL, ALMOST_EMPTY, OVERFLOW, UNDERFLOW;
    logic [10:0] COUNT;
    logic        RAM_WEN_A, RAM_REN_A, RAM_WEN_B, RAM_REN_B;
    logic [3:0]  RAM_BE_A, RAM_WPARITY_A, RAM_RPARITY_B;
    logic [14:0] RAM_ADDR_A, RAM_ADDR_B;
    logic [31:0] RAM_WDATA_A, RAM_RDATA_B;

    int checks = 0;
    int errors = 0;

    logic [35:0] exp_q[$];
    logic [9:0]  m_wptr, m_rptr;
    logic        m_valid;
    logic [35:0] m_data, m_last;
    logic        saw_top, saw_wrap;

    fifo36k_ctrl dut (
        .CLK(clk), .RESET(RESET), .PUSH(PUSH), .PUSH_DATA(PUSH_DATA), .POP(POP),
        .POP_DATA(POP_DATA), .POP_VALID(POP_VALID), .FULL(FULL), .EMPTY(EMPTY),
        .ALMOST_FULL(ALMOST_FULL), .ALMOST_EMPTY(ALMOST_EMPTY), .OVERFLOW(OVERFLOW),
        .UNDERFLOW(UNDERFLOW), .COUNT(COUNT), .RAM_WEN_A(RAM_WEN_A), .RAM_REN_A(RAM_REN_A),
        .RAM_BE_A(RAM_BE_A), .RAM_ADDR_A(RAM_ADDR_A), .RAM_WDATA_A(RAM_WDATA_A),
        .RAM_WPARITY_A(RAM_WPARITY_A), .RAM_WEN_B(RAM_WEN_B), .RAM_REN_B(RAM_REN_B),
        .RAM_ADDR_B(RAM_ADDR_B), .RAM_RDATA_B(RAM_RDATA_B), .RAM_RPARITY_B(RAM_RPARITY_B)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural RAM: synchronous write on A, one-cycle registered read on B
    logic [35:0] mem [0:1023];
    logic [35:0] rd_q;
    always @(posedge clk) begin
        if (RAM_WEN_A) mem[RAM_ADDR_A[14:5]] <= {RAM_WPARITY_A, RAM_WDATA_A};
        if (RAM_REN_B) rd_q <= mem[RAM_ADDR_B[14:5]];
    end
    assign RAM_RDATA_B   = rd_q[31:0];
    assign RAM_RPARITY_B = rd_q[35:32];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [35:0] gen(input int i);
        gen = {4'(i * 7), 32'hC0DE0000 + 32'(i)};
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_count"}, COUNT, 11'd0);
        check({tag, "_empty"}, EMPTY, 1'b1);
        check({tag, "_full"}, FULL, 1'b0);
        check({tag, "_aempty"}, ALMOST_EMPTY, 1'b1);
        check({tag, "_afull"}, ALMOST_FULL, 1'b0);
        check({tag, "_pop_valid"}, POP_VALID, 1'b0);
        check({tag, "_pop_data"}, POP_DATA, 36'h0);
        check({tag, "_ovf"}, OVERFLOW, 1'b0);
        check({tag, "_unf"}, UNDERFLOW, 1'b0);
        check({tag, "_wen_a"}, RAM_WEN_A, 1'b0);
        check({tag, "_ren_b"}, RAM_REN_B, 1'b0);
    endtask

    // driver: reset pulse with PUSH/POP held high to prove they are ignored
    task automatic do_reset();
        @(negedge clk);
        RESET = 1'b1;
        PUSH = 1'b1;
        POP = 1'b1;
        PUSH_DATA = 36'hF_FFFFFFFF;
        #1;
        check_reset_outputs("rst_async");
        @(posedge clk);
        #1;
        check_reset_outputs("rst_edge");
        @(negedge clk);
        RESET = 1'b0;
        PUSH = 1'b0;
        POP = 1'b0;
        exp_q.delete();
        m_wptr = '0;
        m_rptr = '0;
        m_valid = 1'b0;
        m_last = '0;
    endtask

    // driver: one clock of PUSH/POP, checking combinational RAM drive then registered status
    task automatic cycle(input logic push, input logic [35:0] d, input logic pop);
        logic pa, qa;
        @(negedge clk);
        PUSH = push;
        PUSH_DATA = d;
        POP = pop;
        #1;
        pa = push && (exp_q.size() < 1024);
        qa = pop && (exp_q.size() > 0);
        check("ram_wen_a", RAM_WEN_A, pa);
        check("ram_ren_b", RAM_REN_B, qa);
        check("ram_tieoffs", {RAM_REN_A, RAM_WEN_B, RAM_BE_A}, 6'b00_1111);
        if (pa) begin
            check("ram_addr_a", RAM_ADDR_A, {m_wptr, 5'b00000});
            check("ram_wdata_a", RAM_WDATA_A, d[31:0]);
            check("ram_wparity_a", RAM_WPARITY_A, d[35:32]);
            if (RAM_ADDR_A == 15'h7FE0) saw_top = 1'b1;
            else if (saw_top && RAM_ADDR_A == 15'h0000) saw_wrap = 1'b1;
        end
        if (qa) begin
            check("ram_addr_b", RAM_ADDR_B, {m_rptr, 5'b00000});
            m_data = exp_q.pop_front();
            m_rptr = m_rptr + 10'd1;
        end
        if (pa) begin
            exp_q.push_back(d);
            m_wptr = m_wptr + 10'd1;
        end
        m_valid = qa;
        @(posedge clk);
        #1;
        check("count", COUNT, exp_q.size());
        check("empty", EMPTY, exp_q.size() == 0);
        check("full", FULL, exp_q.size() == 1024);
        check("afull", ALMOST_FULL, (1024 - exp_q.size()) <= 4);
        check("aempty", ALMOST_EMPTY, exp_q.size() <= 4);
        check("overflow", OVERFLOW, push && !pa);
        check("underflow", UNDERFLOW, pop && !qa);
        check("pop_valid", POP_VALID, m_valid);
        if (m_valid) begin
            check("pop_data", POP_DATA, m_data);
            m_last = m_data;
        end else begin
            check("pop_data_hold", POP_DATA, m_last);
        end
    endtask

    initial begin
        RESET = 1'b0;
        PUSH = 1'b0;
        POP = 1'b0;
        PUSH_DATA = '0;
        saw_top = 1'b0;
        saw_wrap = 1'b0;
        m_wptr = '0;
        m_rptr = '0;
        m_valid = 1'b0;
        m_data = '0;
        m_last = '0;
        #1;
        do_reset();

        // three words in, three out, then a word carrying parity
        cycle(1'b1, 36'h0_00000001, 1'b0);
        cycle(1'b1, 36'h0_00000002, 1'b0);
        cycle(1'b1, 36'h0_00000003, 1'b0);
        check("basic_count3", COUNT, 11'd3);
        cycle(1'b0, '0, 1'b1);
        check("basic_data1", POP_DATA, 36'h0_00000001);
        cycle(1'b0, '0, 1'b1);
        check("basic_data2", POP_DATA, 36'h0_00000002);
        cycle(1'b0, '0, 1'b1);
        check("basic_data3", POP_DATA, 36'h0_00000003);
        cycle(1'b0, '0, 1'b0);
        check("basic_empty", EMPTY, 1'b1);
        check("basic_hold", POP_DATA, 36'h0_00000003);
        cycle(1'b1, 36'hA_DEADBEEF, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("parity_word", POP_DATA, 36'hA_DEADBEEF);

        // pop on empty with a simultaneous push: no fall-through
        cycle(1'b1, 36'h5_12345678, 1'b1);
        check("unf_pulse", UNDERFLOW, 1'b1);
        check("unf_count", COUNT, 11'd1);
        cycle(1'b0, '0, 1'b0);
        check("unf_no_valid", POP_VALID, 1'b0);
        check("unf_clear", UNDERFLOW, 1'b0);
        // push and pop together at COUNT=1 returns the older word
        cycle(1'b1, 36'h3_87654321, 1'b1);
        check("cnt1_old_word", POP_DATA, 36'h5_12345678);
        check("cnt1_count", COUNT, 11'd1);
        cycle(1'b0, '0, 1'b1);
        check("cnt1_new_word", POP_DATA, 36'h3_87654321);

        // fill to full, overflow, push+pop while full, then drain
        do_reset();
        for (int i = 1; i <= 1024; i++) begin
            cycle(1'b1, gen(i), 1'b0);
            if (i == 4) check("ae_at_4", ALMOST_EMPTY, 1'b1);
            if (i == 5) check("ae_at_5", ALMOST_EMPTY, 1'b0);
            if (i == 1019) check("af_at_1019", ALMOST_FULL, 1'b0);
            if (i == 1020) check("af_at_1020", ALMOST_FULL, 1'b1);
        end
        check("fill_full", FULL, 1'b1);
        check("fill_count", COUNT, 11'd1024);
        cycle(1'b1, gen(5000), 1'b0);
        check("ovf_pulse", OVERFLOW, 1'b1);
        check("ovf_count", COUNT, 11'd1024);
        cycle(1'b0, '0, 1'b0);
        check("ovf_clear", OVERFLOW, 1'b0);
        cycle(1'b1, gen(5001), 1'b1);
        check("full_pp_ovf", OVERFLOW, 1'b1);
        check("full_pp_count", COUNT, 11'd1023);
        check("full_pp_data", POP_DATA, gen(1));
        while (exp_q.size() > 0) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("drain_empty", EMPTY, 1'b1);

        // pointer wrap: 1024 in, 1000 out, 500 in, drain
        do_reset();
        for (int i = 0; i < 1024; i++) cycle(1'b1, gen(i + 100), 1'b0);
        for (int i = 0; i < 1000; i++) cycle(1'b0, '0, 1'b1);
        for (int i = 0; i < 500; i++) cycle(1'b1, gen(i + 3000), 1'b0);
        check("wrap_count", COUNT, 11'd524);
        while (exp_q.size() > 0) cycle(1'b0, '0, 1'b1);
        cycle(1'b0, '0, 1'b0);
        check("wrap_saw_7fe0", saw_top, 1'b1);
        check("wrap_saw_0000", saw_wrap, 1'b1);

        // reset in the cycle after a pop kills the in-flight read
        cycle(1'b1, 36'h1_11111111, 1'b0);
        cycle(1'b1, 36'h2_22222222, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("pre_rst_valid", POP_VALID, 1'b1);
        do_reset();
        cycle(1'b0, '0, 1'b0);
        check("post_rst_valid", POP_VALID, 1'b0);
        check("post_rst_empty", EMPTY, 1'b1);
        cycle(1'b1, 36'h7_77777777, 1'b0);
        cycle(1'b0, '0, 1'b1);
        check("post_rst_data", POP_DATA, 36'h7_77777777);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
